// File: rtl/counter_run_ctrl_if.sv
// Button/tick request lines and status outputs of the run/stop/clear sequencer.
// master = request source (debouncers, tick generator); slave = counter_run_ctrl.
interface counter_run_ctrl_if #(
  parameter int CNT_W = 14
);
  logic             i_btn_run;
  logic             i_btn_clear;
  logic             i_btn_mode;
  logic             i_tick;
  logic             o_tick_en;
  logic             o_tick_clr;
  logic [CNT_W-1:0] o_count;
  logic             o_dir;
  logic [1:0]       o_state;
  logic             o_done;

  modport master (
    output i_btn_run, i_btn_clear, i_btn_mode, i_tick,
    input  o_tick_en, o_tick_clr, o_count, o_dir, o_state, o_done
  );

  modport slave (
    input  i_btn_run, i_btn_clear, i_btn_mode, i_tick,
    output o_tick_en, o_tick_clr, o_count, o_dir, o_state, o_done
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run/stop/clear sequencer owning the 0..COUNT_MAX count register and its direction.
// Optional macro COUNTER_AUTO_STOP_EN: stop at terminal count instead of wrapping.
module counter_run_ctrl #(
  parameter int COUNT_MAX = 9999,
  parameter int CNT_W     = 14
) (
  input logic              clk,
  input logic              rst,
  counter_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STOP  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(COUNT_MAX);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] step_val;
  logic [CNT_W-1:0] start_val;
  logic [CNT_W-1:0] term_val;
  logic             dir;
  logic             tick_en;
  logic             tick_clr;
  logic             done;
  logic             hit_term;
`ifdef COUNTER_AUTO_STOP_EN
  logic             at_term;
`endif

  assign start_val = dir ? MAX_V : '0;
  assign term_val  = dir ? '0 : MAX_V;

  // Next count value with wrap so the register never leaves 0..COUNT_MAX.
  always_comb begin
    if (dir) step_val = (count == '0)    ? MAX_V : count - CNT_W'(1);
    else     step_val = (count == MAX_V) ? '0    : count + CNT_W'(1);
  end

  assign hit_term = bus.i_tick && (step_val == term_val);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.i_btn_clear)    state_next = CLEAR;
        else if (bus.i_btn_run) state_next = RUN;
      end
      RUN: begin
        if (bus.i_btn_clear)    state_next = CLEAR;
        else if (bus.i_btn_run) state_next = STOP;
`ifdef COUNTER_AUTO_STOP_EN
        else if (hit_term)      state_next = STOP;
`endif
      end
      STOP: begin
        if (bus.i_btn_clear)    state_next = CLEAR;
        else if (bus.i_btn_run) state_next = RUN;
      end
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      dir      <= 1'b0;
      tick_en  <= 1'b0;
      tick_clr <= 1'b0;
      done     <= 1'b0;
`ifdef COUNTER_AUTO_STOP_EN
      at_term  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_en  <= (state_next == RUN);
      tick_clr <= (state_next == CLEAR);
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.i_btn_clear && !bus.i_btn_run && bus.i_btn_mode) begin
            dir   <= ~dir;
            count <= dir ? '0 : MAX_V;
          end
        end
        RUN: begin
          if (!bus.i_btn_clear && bus.i_tick) begin
            count <= step_val;
            done  <= hit_term;
`ifdef COUNTER_AUTO_STOP_EN
            if (hit_term) at_term <= 1'b1;
`endif
          end
        end
        STOP: begin
`ifdef COUNTER_AUTO_STOP_EN
          if (state_next != STOP) at_term <= 1'b0;
          if (!bus.i_btn_clear && bus.i_btn_run && at_term) count <= start_val;
`endif
          if (!bus.i_btn_clear && !bus.i_btn_run && bus.i_btn_mode) dir <= ~dir;
        end
        CLEAR:   count <= start_val;
        default: count <= count;
      endcase
    end
  end

  assign bus.o_state    = state;
  assign bus.o_count    = count;
  assign bus.o_dir      = dir;
  assign bus.o_tick_en  = tick_en;
  assign bus.o_tick_clr = tick_clr;
  assign bus.o_done     = done;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: directed pulses push expected snapshots,
// monitors pop one snapshot after each clock edge or asynchronous reset assertion.
module tb_counter_run_ctrl;
  localparam int CNT_W = 14;
  localparam int CMAX  = 9999;
`ifdef COUNTER_AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STOP = 2'b10, S_CLR = 2'b11;
  // Stimulus nibble order: {run, clear, mode, tick}
  localparam logic [3:0] NONE = 4'b0000, RUNB = 4'b1000, CLRB = 4'b0100,
                         MODE = 4'b0010, TICK = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  counter_run_ctrl #(.COUNT_MAX(CMAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input exp_t e);
    logic [CNT_W+5:0] got, want;
    got  = {bus.o_state, bus.o_tick_en, bus.o_tick_clr, bus.o_dir, bus.o_done, bus.o_count};
    want = {e.st, e.st == S_RUN, e.st == S_CLR, e.dir, e.done, e.cnt};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d en=%b clr=%b dir=%b done=%b count=%0d, want state=%0d en=%b clr=%b dir=%b done=%b count=%0d",
               e.name, bus.o_state, bus.o_tick_en, bus.o_tick_clr, bus.o_dir, bus.o_done, bus.o_count,
               e.st, e.st == S_RUN, e.st == S_CLR, e.dir, e.done, e.cnt);
    end
  endtask

  task automatic pushExp(input string nm, input logic [1:0] st, input int cnt,
                         input logic d, input logic dn);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.cnt  = CNT_W'(cnt);
    e.dir  = d;
    e.done = dn;
    sb.push_back(e);
  endtask

  // Drive one cycle of pulses on the falling edge and queue the state expected after the next rising edge.
  task automatic applyStimulus(input string nm, input logic [3:0] btn, input logic [1:0] st,
                               input int cnt, input logic d, input logic dn);
    @(negedge clk);
    bus.i_btn_run   = btn[3];
    bus.i_btn_clear = btn[2];
    bus.i_btn_mode  = btn[1];
    bus.i_tick      = btn[0];
    pushExp(nm, st, cnt, d, dn);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  always @(negedge rst) begin
    #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    bus.i_btn_run   = 1'b0;
    bus.i_btn_clear = 1'b0;
    bus.i_btn_mode  = 1'b0;
    bus.i_tick      = 1'b0;

    #2;
    pushExp("reset", S_IDLE, 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("idle",          NONE, S_IDLE, 0, 1'b0, 1'b0);
    applyStimulus("run_start",     RUNB, S_RUN,  0, 1'b0, 1'b0);
    applyStimulus("tick1",         TICK, S_RUN,  1, 1'b0, 1'b0);
    applyStimulus("tick2",         TICK, S_RUN,  2, 1'b0, 1'b0);
    applyStimulus("tick3",         TICK, S_RUN,  3, 1'b0, 1'b0);
    applyStimulus("run_stop",      RUNB, S_STOP, 3, 1'b0, 1'b0);
    applyStimulus("tick_in_stop",  TICK, S_STOP, 3, 1'b0, 1'b0);
    applyStimulus("mode_in_stop",  MODE, S_STOP, 3, 1'b1, 1'b0);
    applyStimulus("mode_back",     MODE, S_STOP, 3, 1'b0, 1'b0);
    applyStimulus("resume",        RUNB, S_RUN,  3, 1'b0, 1'b0);
    applyStimulus("mode_in_run",   MODE, S_RUN,  3, 1'b0, 1'b0);
    applyStimulus("clr_run_tick",  CLRB | RUNB | TICK, S_CLR, 3, 1'b0, 1'b0);
    applyStimulus("clear_to_idle", NONE, S_IDLE, 0, 1'b0, 1'b0);

    applyStimulus("run_up", RUNB, S_RUN, 0, 1'b0, 1'b0);
    for (int i = 1; i <= CMAX; i++)
      applyStimulus("up_count", TICK, (AUTO && i == CMAX) ? S_STOP : S_RUN, i, 1'b0, i == CMAX);
    if (AUTO) begin
      applyStimulus("tick_at_term", TICK, S_STOP, CMAX, 1'b0, 1'b0);
      applyStimulus("reload_up",    RUNB, S_RUN,  0,    1'b0, 1'b0);
    end else begin
      applyStimulus("wrap_up",      TICK, S_RUN,  0,    1'b0, 1'b0);
    end
    for (int i = 1; i <= 5; i++)
      applyStimulus("to_five", TICK, S_RUN, i, 1'b0, 1'b0);
    applyStimulus("run_and_tick",  RUNB | TICK, S_STOP, 6, 1'b0, 1'b0);
    applyStimulus("clear_stop",    CLRB, S_CLR,  6, 1'b0, 1'b0);
    applyStimulus("run_in_clear",  RUNB, S_IDLE, 0, 1'b0, 1'b0);

    applyStimulus("mode_idle",     MODE, S_IDLE, CMAX, 1'b1, 1'b0);
    applyStimulus("tick_in_idle",  TICK, S_IDLE, CMAX, 1'b1, 1'b0);
    applyStimulus("run_down",      RUNB, S_RUN,  CMAX, 1'b1, 1'b0);
    applyStimulus("down1",         TICK, S_RUN,  CMAX - 1, 1'b1, 1'b0);
    applyStimulus("down2",         TICK, S_RUN,  CMAX - 2, 1'b1, 1'b0);
    for (int i = CMAX - 3; i >= 0; i--)
      applyStimulus("down_count", TICK, (AUTO && i == 0) ? S_STOP : S_RUN, i, 1'b1, i == 0);
    if (AUTO)
      applyStimulus("reload_down", RUNB, S_RUN, CMAX, 1'b1, 1'b0);
    else
      applyStimulus("wrap_down",   TICK, S_RUN, CMAX, 1'b1, 1'b0);

    applyStimulus("down_again",    TICK, S_RUN,  CMAX - 1, 1'b1, 1'b0);
    applyStimulus("clr_tick",      CLRB | TICK, S_CLR, CMAX - 1, 1'b1, 1'b0);
    applyStimulus("clear_down",    NONE, S_IDLE, CMAX, 1'b1, 1'b0);
    applyStimulus("mode_run_prio", MODE | RUNB, S_RUN, CMAX, 1'b1, 1'b0);
    applyStimulus("stop_again",    RUNB, S_STOP, CMAX, 1'b1, 1'b0);
    applyStimulus("mode_stop_dir", MODE, S_STOP, CMAX, 1'b0, 1'b0);
    applyStimulus("clear_up",      CLRB, S_CLR,  CMAX, 1'b0, 1'b0);
    applyStimulus("idle_up",       NONE, S_IDLE, 0, 1'b0, 1'b0);
    applyStimulus("run_42",        RUNB, S_RUN,  0, 1'b0, 1'b0);
    for (int i = 1; i <= 42; i++)
      applyStimulus("to_42", TICK, S_RUN, i, 1'b0, 1'b0);
    applyStimulus("hold_42",       NONE, S_RUN,  42, 1'b0, 1'b0);

    // Assert reset between edges; the reset monitor samples before the next rising edge.
    @(posedge clk);
    #2;
    pushExp("async_reset", S_IDLE, 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("after_reset",   NONE, S_IDLE, 0, 1'b0, 1'b0);
    applyStimulus("final_idle",    NONE, S_IDLE, 0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run/stop/clear sequencer for the 0–9999 counter datapath. Takes single-cycle button pulses from the debouncers and tick pulses from the tick generator. Drives the tick generator's enable/clear and owns the count register and count direction. Sits between the button debouncers and the FND display path.

## Interface

Parameters:
- `COUNT_MAX`, 9999: terminal count value.
- `CNT_W`, 14: count width; must satisfy 2^CNT_W > COUNT_MAX.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `i_btn_run` input 1: run/stop request, 1-cycle pulse.
- `i_btn_clear` input 1: clear request, 1-cycle pulse.
- `i_btn_mode` input 1: direction toggle request, 1-cycle pulse.
- `i_tick` input 1: count tick from the tick generator, 1-cycle pulse.
- `o_tick_en` output 1: tick generator enable, level.
- `o_tick_clr` output 1: tick generator clear, 1-cycle pulse.
- `o_count` output CNT_W: current count, binary.
- `o_dir` output 1: direction; 0 = up, 1 = down.
- `o_state` output 2: FSM state code.
- `o_done` output 1: terminal-count pulse.

## Operation

FSM states: IDLE=2'b00, RUN=2'b01, STOP=2'b10, CLEAR=2'b11. All outputs except `o_count` are Moore-decoded from registered state.

Start value is 0 when `o_dir`=0 and COUNT_MAX when `o_dir`=1. Terminal value is the opposite.

- **IDLE**
  - clear → CLEAR.
  - else run → RUN.
  - else mode toggles `o_dir` and loads `o_count` with the start value of the new direction; state stays IDLE.
- **RUN**
  - `o_tick_en`=1.
  - Each `i_tick` steps `o_count` by +1 (up) or −1 (down).
  - clear → CLEAR; else run → STOP.
  - mode is ignored.
- **STOP**
  - `o_tick_en`=0; count is held.
  - clear → CLEAR; else run → RUN.
  - mode toggles `o_dir` only; count is unchanged.
- **CLEAR**
  - Lasts exactly one cycle with `o_tick_clr`=1.
  - `o_count` is loaded with the start value for the current `o_dir`; `o_dir` is retained.
  - Unconditional next state is IDLE.
  - All buttons pulsing during CLEAR are dropped.

Priority for simultaneous pulses is clear > run > mode. Only the highest-priority valid request acts; the others are dropped, not queued.

`i_tick` is acted on only in RUN. It is ignored in IDLE, STOP and CLEAR.

Wrap behaviour (without the macro, see Configuration):
- Up: COUNT_MAX → 0.
- Down: 0 → COUNT_MAX.
- Arithmetic uses CNT_W bits. `o_count` never leaves 0..COUNT_MAX.

## Timing

- Reset (`rst`=0) asynchronously forces: state IDLE, `o_count`=0, `o_dir`=0, `o_tick_en`=0, `o_tick_clr`=0, `o_done`=0, `o_state`=2'b00.
- Reset mid-operation discards any pending count step.
- A button pulse sampled at edge N changes state at edge N. The decoded outputs (`o_tick_en`, `o_tick_clr`, `o_state`) are valid after edge N, i.e. one cycle of latency from the pulse.
- `i_tick` sampled in RUN at edge N updates `o_count` at edge N.
- Run pulse and `i_tick` in the same RUN cycle: the step is applied and the state goes to STOP at the same edge.
- Clear pulse and `i_tick` in the same RUN cycle: clear wins; the count is loaded at the following CLEAR cycle and the step is discarded.
- `o_done` is a 1-cycle pulse, registered at the same edge as the step that reaches the terminal value.

## Configuration

Macro `COUNTER_AUTO_STOP_EN`:
- **Defined:** a tick in RUN that makes `o_count` equal the terminal value moves the FSM to STOP at that edge and pulses `o_done`. A subsequent run pulse from STOP first reloads the start value, then resumes RUN.
- **Undefined:** the counter wraps as described in Operation and the FSM stays in RUN. `o_done` still pulses on each transition to the terminal value.

## Test plan

- **Reset then count up:** reset, run pulse, 3 ticks → `o_tick_en`=1 one cycle after the pulse, `o_count`=3, `o_state`=01.
- **Wrap up (macro undefined):** preload to 9999 via 9999 ticks in RUN, one more tick → `o_count`=0, `o_done` pulses once, state remains RUN.
- **Down mode from IDLE:** mode pulse in IDLE → `o_dir`=1, `o_count`=9999. Run, 2 ticks → 9997.
- **Simultaneous events:** run+clear in RUN → CLEAR (`o_tick_clr` 1 cycle) then IDLE, `o_count`=0. Run+tick in RUN at count 5 → `o_count`=6, state STOP.
- **Auto-stop (macro defined):** down mode, count reaches 0 → state STOP, `o_done`=1 for one cycle. Next run pulse → `o_count`=9999, state RUN.
- **Async reset mid-RUN:** drop `rst` to 0 between edges at count 42 → all outputs reach reset values immediately, without waiting for a clock edge.
